// File: rtl/adc_result_buffer_pkg.sv
// Shared constants for the ADC result buffer and its SAR controller instantiation.
//   ADC_RESULT_BITS : width of one conversion result (matches controller MATRIX_BITS)
//   ADC_BUF_DEPTH   : number of FIFO entries (power of two, >= 2)
//   ADC_CNT_BITS    : width of the conversion counter
package adc_result_buffer_pkg;

  localparam int unsigned ADC_RESULT_BITS = 12;
  localparam int unsigned ADC_BUF_DEPTH   = 8;
  localparam int unsigned ADC_CNT_BITS    = 16;

  // Width of a level/threshold field able to hold 0..depth inclusive.
  function automatic int unsigned level_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_result_buffer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used by adc_result_buffer.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   flush      : empty the FIFO next cycle (pointers and level to 0)
//   push       : write wdata; ignored when full unless pop is also asserted
//   pop        : remove head entry; ignored when empty
//   wdata      : word to write
//   rdata      : head entry, 0 when empty
//   level      : entries held, 0..DEPTH
//   full/empty : derived from the level counter
module adc_result_buffer_sync_fifo
  import adc_result_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = ADC_RESULT_BITS,
  parameter int unsigned DEPTH = ADC_BUF_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH):0]         level,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // A pop frees the slot a simultaneous push needs, so full-with-pop still writes.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level counter decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en && !rst && !flush) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/adc_result_buffer.sv
// Captures each finished SAR conversion into a small FIFO and presents it on a
// valid/ready read port, with fill level, sticky overflow, threshold irq and a
// wrapping conversion counter.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   result_in           : controller conversion result
//   conv_finished_in    : controller done level; a rising edge captures result_in
//   clear_in            : flush FIFO, clear overflow and counter
//   threshold_in        : irq fill threshold, 0 disables the irq
//   data_out            : head word, 0 when empty
//   data_valid_out      : FIFO non-empty
//   data_ready_in       : consumer takes data_out this cycle
//   fill_level_out      : entries held, 0..DEPTH
//   overflow_out        : sticky, a capture was dropped
//   threshold_irq_out   : fill level >= nonzero threshold
//   conv_count_out      : captures seen including dropped ones, wraps
module adc_result_buffer
  import adc_result_buffer_pkg::*;
#(
  parameter int unsigned RESULT_BITS = ADC_RESULT_BITS,
  parameter int unsigned DEPTH       = ADC_BUF_DEPTH,
  parameter int unsigned CNT_BITS    = ADC_CNT_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RESULT_BITS-1:0]   result_in,
  input  logic                     conv_finished_in,
  input  logic                     clear_in,
  input  logic [$clog2(DEPTH):0]   threshold_in,
  output logic [RESULT_BITS-1:0]   data_out,
  output logic                     data_valid_out,
  input  logic                     data_ready_in,
  output logic [$clog2(DEPTH):0]   fill_level_out,
  output logic                     overflow_out,
  output logic                     threshold_irq_out,
  output logic [CNT_BITS-1:0]      conv_count_out
);

  logic                  conv_finished_q;
  logic                  overflow_q, overflow_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic                  cap;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign cap = conv_finished_in & ~conv_finished_q;
  assign pop = data_valid_out & data_ready_in;

  adc_result_buffer_sync_fifo #(
    .WIDTH (RESULT_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear_in),
    .push  (cap & ~clear_in),
    .pop   (pop & ~clear_in),
    .wdata (result_in),
    .rdata (data_out),
    .level (fill_level_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    overflow_d = overflow_q;
    count_d    = count_q;
    if (clear_in) begin
      overflow_d = 1'b0;
      count_d    = '0;
    end else if (cap) begin
      count_d = count_q + CNT_BITS'(1);
      if (fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset high so a done level already asserted at release is not an edge.
      conv_finished_q <= 1'b1;
      overflow_q      <= 1'b0;
      count_q         <= '0;
    end else begin
      conv_finished_q <= conv_finished_in;
      overflow_q      <= overflow_d;
      count_q         <= count_d;
    end
  end

  assign data_valid_out    = ~fifo_empty;
  assign overflow_out      = overflow_q;
  assign conv_count_out    = count_q;
  assign threshold_irq_out = (threshold_in != '0) && (fill_level_out >= threshold_in);

endmodule

// File: tb/tb_adc_result_buffer.sv
// Self-checking bench for adc_result_buffer: a queue-based model updated every
// clock, compared against two DUT instances (16-bit and 4-bit counters) on every
// falling edge, plus directed scenarios with literal expectations.
module tb_adc_result_buffer;

  localparam int unsigned RB    = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RB-1:0] result = '0;
  logic          conv = 1'b0;
  logic          clear = 1'b0;
  logic [LW-1:0] thr = '0;
  logic          ready = 1'b0;

  logic [RB-1:0] data_a, data_b;
  logic          valid_a, valid_b;
  logic [LW-1:0] level_a, level_b;
  logic          ovf_a, ovf_b;
  logic          irq_a, irq_b;
  logic [15:0]   cnt_a;
  logic [3:0]    cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_result_buffer #(.RESULT_BITS(RB), .DEPTH(DEPTH), .CNT_BITS(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .result_in         (result),
    .conv_finished_in  (conv),
    .clear_in          (clear),
    .threshold_in      (thr),
    .data_out          (data_a),
    .data_valid_out    (valid_a),
    .data_ready_in     (ready),
    .fill_level_out    (level_a),
    .overflow_out      (ovf_a),
    .threshold_irq_out (irq_a),
    .conv_count_out    (cnt_a)
  );

  adc_result_buffer #(.RESULT_BITS(RB), .DEPTH(DEPTH), .CNT_BITS(4)) dut_w (
    .clk               (clk),
    .rst               (rst),
    .result_in         (result),
    .conv_finished_in  (conv),
    .clear_in          (clear),
    .threshold_in      (thr),
    .data_out          (data_b),
    .data_valid_out    (valid_b),
    .data_ready_in     (ready),
    .fill_level_out    (level_b),
    .overflow_out      (ovf_b),
    .threshold_irq_out (irq_b),
    .conv_count_out    (cnt_b)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  mq[$];
  bit  mprev = 1'b1;
  bit  movf = 1'b0;
  int  mcnt = 0;
  bit  started = 1'b0;

  always @(posedge clk) begin
    bit mcap, mpop;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      mprev = 1'b1;
      movf  = 1'b0;
      mcnt  = 0;
    end else begin
      mcap  = conv && !mprev;
      mpop  = (mq.size() > 0) && ready;
      mprev = conv;
      if (clear) begin
        mq.delete();
        movf = 1'b0;
        mcnt = 0;
      end else begin
        if (mpop) void'(mq.pop_front());
        if (mcap) begin
          mcnt++;
          if (mq.size() < DEPTH) mq.push_back(int'(result));
          else movf = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int sz, head;
    bit eirq;
    if (started) begin
      sz   = mq.size();
      head = (sz > 0) ? mq[0] : 0;
      eirq = (thr != 0) && (sz >= int'(thr));
      check("valid", valid_a, sz > 0);
      check("data", data_a, head);
      check("level", level_a, sz);
      check("overflow", ovf_a, movf);
      check("irq", irq_a, eirq);
      check("count16", cnt_a, mcnt % 65536);
      check("w_data", data_b, head);
      check("w_level", level_b, sz);
      check("w_valid_ovf_irq", {valid_b, ovf_b, irq_b}, {sz > 0, movf, eirq});
      check("count4", cnt_b, mcnt % 16);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int val);
    result = RB'(val);
    conv   = 1'b1;
    step();
    conv   = 1'b0;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  initial begin
    int seq2 [6] = '{2048, 806, 13, 489, 4095, 0};
    int exp4 [8] = '{201, 301, 401, 501, 601, 701, 801, 999};

    // 1: reset with done held high; release must not capture
    rst = 1'b1; conv = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step(); step();
    check("t1_level", level_a, 0);
    check("t1_valid", valid_a, 0);
    check("t1_data", data_a, 0);
    check("t1_count", cnt_a, 0);
    conv = 1'b0;
    step();

    // 2: fill six, irq at threshold 6, then drain in order
    thr = LW'(6); ready = 1'b0;
    foreach (seq2[i]) capture(seq2[i]);
    check("t2_level", level_a, 6);
    check("t2_irq", irq_a, 1);
    ready = 1'b1;
    foreach (seq2[i]) begin
      check("t2_order", data_a, seq2[i]);
      check("t2_valid", valid_a, 1);
      step();
    end
    check("t2_empty", valid_a, 0);
    ready = 1'b0; thr = '0;

    // 3: long done pulse gives one entry
    do_clear();
    result = RB'(806); conv = 1'b1;
    repeat (5) step();
    conv = 1'b0;
    step();
    check("t3_level", level_a, 1);
    check("t3_count", cnt_a, 1);
    check("t3_data", data_a, 806);

    // 4a: ninth capture on full FIFO is dropped
    do_clear();
    for (int i = 1; i <= 8; i++) capture(i * 100 + 1);
    capture(900);
    check("t4_ovf", ovf_a, 1);
    check("t4_level", level_a, 8);
    check("t4_count", cnt_a, 9);
    check("t4_head", data_a, 101);

    // 4b: ninth capture with a simultaneous pop is kept as the tail
    do_clear();
    for (int i = 1; i <= 8; i++) capture(i * 100 + 1);
    result = RB'(999); conv = 1'b1; ready = 1'b1;
    step();
    conv = 1'b0; ready = 1'b0;
    step();
    check("t4b_ovf", ovf_a, 0);
    check("t4b_level", level_a, 8);
    ready = 1'b1;
    foreach (exp4[i]) begin
      check("t4b_order", data_a, exp4[i]);
      step();
    end
    ready = 1'b0;
    check("t4b_empty", level_a, 0);

    // 5: clear coincident with capture and pop wins
    capture(1); capture(2); capture(3);
    clear = 1'b1; conv = 1'b1; result = RB'(4095); ready = 1'b1;
    step();
    clear = 1'b0; conv = 1'b0; ready = 1'b0;
    step();
    check("t5_level", level_a, 0);
    check("t5_ovf", ovf_a, 0);
    check("t5_count", cnt_a, 0);

    // 6: counter wrap, observed on the 4-bit instance
    ready = 1'b1;
    for (int i = 0; i < 15; i++) capture(i);
    check("t6_cnt15", cnt_b, 15);
    capture(42);
    check("t6_wrap", cnt_b, 0);
    check("t6_cnt16", cnt_a, 16);
    ready = 1'b0;

    // Random phase: varied read pressure, rare clears and resets
    for (int seg = 0; seg < 12; seg++) begin
      int rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      thr = LW'($urandom_range(0, DEPTH));
      for (int c = 0; c < 300; c++) begin
        rst    = ($urandom_range(0, 399) == 0);
        clear  = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 2) == 0) conv = ~conv;
        result = RB'($urandom_range(0, 4095));
        ready  = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 49) == 0) thr = LW'($urandom_range(0, DEPTH));
        step();
      end
    end
    rst = 1'b0; clear = 1'b0; conv = 1'b0; ready = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
